hci_sink_job_scheduler: RTL and testbench

Shares one `hci_core_sink_v2` between `NB_REQ` independent requesters (engine contexts), arbitrating their store-job submissions round-robin onto the sink's single `ctrl_i` port. It records the owner of every accepted job in order, and routes each sink `done` pulse back to the owning requester. It also exposes the ID of the job currently executing, so the surrounding datapath can steer the matching HWPE-Stream into the sink. It sits between the engine controllers and the sink streamer's control plane.

---
 rtl/hci_sink_job_scheduler_pkg.sv | 36 +++
 rtl/hwpe_stream_fifo.sv | 63 ++++++
 rtl/hci_sink_job_scheduler.sv | 179 +++++++++++++++++
 tb/tb_hci_sink_job_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_sink_job_scheduler_pkg.sv
// Shared types for the sink job scheduler: the slice of the HCI streamer
// control/flag structures it touches, its FSM state type and an ID-width helper.
package hci_sink_job_scheduler_pkg;

  // Address-generator configuration carried with every store job.
  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
  } ctrl_addressgen_v3_t;

  // Control word presented to the sink's ctrl_i port.
  typedef struct packed {
    logic                valid;
    ctrl_addressgen_v3_t addressgen_ctrl;
  } hci_streamer_v2_ctrl_t;

  // Flags returned by the sink: ready to take a job, job finished.
  typedef struct packed {
    logic ready;
    logic done;
  } hci_streamer_v2_flags_t;

  // IDLE while no job is outstanding, ACTIVE otherwise.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } hci_sched_state_t;

  // Width of a requester ID; never narrower than one bit.
  function automatic int unsigned sched_id_width(input int unsigned nb_req);
    return (nb_req > 1) ? $clog2(nb_req) : 1;
  endfunction

endpackage

// File: rtl/hwpe_stream_fifo.sv
// Small synchronous FIFO used to record job owners in acceptance order.
// A push while full is taken only when a pop happens in the same cycle.
module hwpe_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int unsigned USAGE_W   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [USAGE_W-1:0]    usage_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [USAGE_W-1:0]    usage_q;
  logic                  push_en;
  logic                  pop_en;

  // Qualify push/pop against occupancy.
  always_comb begin
    empty_o = (usage_q == '0);
    full_o  = (usage_q == USAGE_W'(FIFO_DEPTH));
    pop_en  = pop_i & ~empty_o;
    push_en = push_i & (~full_o | pop_en);
    data_o  = mem_q[rd_ptr_q];
    usage_o = usage_q;
  end

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push_en && !pop_en) usage_q <= usage_q + USAGE_W'(1);
      else if (pop_en && !push_en) usage_q <= usage_q - USAGE_W'(1);
    end
  end

endmodule

// File: rtl/hci_sink_job_scheduler.sv
// Shares one HCI sink streamer between NB_REQ requesters: round-robin job
// arbitration onto the sink ctrl port, in-order owner tracking, done routing
// back to the owner, and the ID of the job currently executing.
//
// Handshake: a requester raises req_valid_i and holds req_ctrl_i stable until
// it sees its req_ready_o bit high in the same cycle; that cycle is the accept.
// Toward the sink, ctrl_o.valid is presented and the job is taken in any cycle
// where flags_i.ready is also high. req_ready_o is never asserted without the
// sink accepting, so both sides of the accept happen in one cycle.
module hci_sink_job_scheduler
  import hci_sink_job_scheduler_pkg::*;
#(
  parameter int unsigned NB_REQ   = 4,
  parameter int unsigned ID_DEPTH = 4,
  parameter int unsigned CNT_W    = $clog2(ID_DEPTH + 1),
  localparam int unsigned ID_W    = sched_id_width(NB_REQ),
  localparam int unsigned USAGE_W = $clog2(ID_DEPTH + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic                                  enable_i,
  input  logic                [NB_REQ-1:0]      req_valid_i,
  input  ctrl_addressgen_v3_t [NB_REQ-1:0]      req_ctrl_i,
  output logic                [NB_REQ-1:0]      req_ready_o,
  output logic                [NB_REQ-1:0]      done_o,
  output logic                [NB_REQ-1:0]      busy_o,
  output hci_streamer_v2_ctrl_t                 ctrl_o,
  input  hci_streamer_v2_flags_t                flags_i,
  output logic                                  active_valid_o,
  output logic                [$clog2(NB_REQ)-1:0] active_id_o,
  output logic                                  error_o,
  output hci_sched_state_t                      state_o
);

  logic [ID_W-1:0]               rr_ptr_q;
  logic [ID_W-1:0]               grant;
  logic [ID_W-1:0]               head;
  logic                          any_valid;
  logic                          ctrl_valid;
  logic                          id_full;
  logic                          accept;
  logic                          pop;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic [USAGE_W-1:0]            fifo_usage;
  logic [NB_REQ-1:0]             inc_vec;
  logic [NB_REQ-1:0]             dec_vec;
  logic [NB_REQ-1:0][CNT_W-1:0]  cnt_q;
  logic [NB_REQ-1:0]             done_q;
  logic                          error_q;
  hci_sched_state_t              state_q;
  hci_sched_state_t              state_d;

  // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    int   sum;
    logic found;
    grant = '0;
    found = 1'b0;
    sum   = 0;
    for (int k = 0; k < int'(NB_REQ); k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= int'(NB_REQ)) sum = sum - int'(NB_REQ);
      if (!found && req_valid_i[ID_W'(sum)]) begin
        found = 1'b1;
        grant = ID_W'(sum);
      end
    end
  end

  // Sink request, accept/pop qualification and per-requester event vectors.
  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  always_comb begin
    any_valid   = |req_valid_i;
    pop         = flags_i.done & enable_i & ~fifo_empty;
    id_full     = fifo_full & ~pop;
    ctrl_valid  = enable_i & any_valid & ~id_full;
    accept      = ctrl_valid & flags_i.ready;
    ctrl_o.valid           = ctrl_valid;
    ctrl_o.addressgen_ctrl = any_valid ? req_ctrl_i[grant] : '0;
    req_ready_o = '0;
    inc_vec     = '0;
    dec_vec     = '0;
    if (accept) begin
      req_ready_o[grant] = 1'b1;
      inc_vec[grant]     = 1'b1;
    end
    if (pop) dec_vec[head] = 1'b1;
  end

  // Owner FIFO: one entry per accepted, not yet completed job.
  hwpe_stream_fifo #(
    .DATA_WIDTH (ID_W),
    .FIFO_DEPTH (ID_DEPTH)
  ) i_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (accept),
    .data_i  (grant),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .usage_o (fifo_usage)
  );

  // Round-robin pointer moves past the winner on every accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (clear_i) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= (grant == ID_W'(NB_REQ - 1)) ? '0 : grant + ID_W'(1);
    end
  end

  // Outstanding-job counters; a push and pop to the same owner cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NB_REQ); i++) begin
        if (inc_vec[i] && !dec_vec[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        else if (dec_vec[i] && !inc_vec[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Registered done pulse to the owner and sticky spurious-done error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q  <= '0;
      error_q <= 1'b0;
    end else if (clear_i) begin
      done_q  <= '0;
      error_q <= 1'b0;
    end else if (enable_i) begin
      done_q <= dec_vec;
      if (flags_i.done && fifo_empty) error_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: ACTIVE while any job is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE:  if (pop && !accept && fifo_usage == USAGE_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs.
  always_comb begin
    for (int i = 0; i < int'(NB_REQ); i++) busy_o[i] = (cnt_q[i] != '0);
    done_o         = done_q;
    error_o        = error_q;
    active_valid_o = (state_q == ACTIVE);
    active_id_o    = (state_q == ACTIVE) ? head : '0;
    state_o        = state_q;
  end

endmodule

// File: tb/tb_hci_sink_job_scheduler.sv
// Directed bench for hci_sink_job_scheduler with hand-computed expectations.
module tb_hci_sink_job_scheduler;
  import hci_sink_job_scheduler_pkg::*;

  localparam int NB_REQ = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                             clear;
  logic                             enable;
  logic [NB_REQ-1:0]                req_valid;
  ctrl_addressgen_v3_t [NB_REQ-1:0] req_ctrl;
  logic [NB_REQ-1:0]                req_ready;
  logic [NB_REQ-1:0]                done;
  logic [NB_REQ-1:0]                busy;
  hci_streamer_v2_ctrl_t            ctrl;
  hci_streamer_v2_flags_t           flags;
  logic                             active_valid;
  logic [1:0]                       active_id;
  logic                             error;
  hci_sched_state_t                 state;

  hci_sink_job_scheduler #(
    .NB_REQ   (NB_REQ),
    .ID_DEPTH (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .enable_i       (enable),
    .req_valid_i    (req_valid),
    .req_ctrl_i     (req_ctrl),
    .req_ready_o    (req_ready),
    .done_o         (done),
    .busy_o         (busy),
    .ctrl_o         (ctrl),
    .flags_i        (flags),
    .active_valid_o (active_valid),
    .active_id_o    (active_id),
    .error_o        (error),
    .state_o        (state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [NB_REQ-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    flags     = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      req_ctrl[i].base_addr = 32'h1000 * (i + 1);
      req_ctrl[i].tot_len   = 32'(i + 8);
      req_ctrl[i].d0_len    = 32'(i + 2);
      req_ctrl[i].d0_stride = 32'h4;
    end

    // Reset values
    #1;
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ctrl_valid", ctrl.valid, 0);
    check_eq("rst_ctrl_base", ctrl.addressgen_ctrl.base_addr, 0);
    check_eq("rst_active_valid", active_valid, 0);
    check_eq("rst_active_id", active_id, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_state", state, IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention: grants 0,1,2,3 fill the 4-deep owner FIFO
    req_valid   = 4'hF;
    flags.ready = 1'b1;
    settle();
    check_eq("t1_base0", ctrl.addressgen_ctrl.base_addr, 32'h1000);
    for (int k = 0; k < 4; k++) begin
      check_eq("t1_grant", req_ready, 32'(1 << k));
      exp_q.push_back(4'(1 << k));
      tick();
      if (k == 0) begin
        check_eq("t1_active_valid", active_valid, 1);
        check_eq("t1_active_id", active_id, 0);
        check_eq("t1_state", state, ACTIVE);
      end
    end
    // Full FIFO: no request, no ready, pointer held
    check_eq("t1_full_valid", ctrl.valid, 0);
    check_eq("t1_full_ready", req_ready, 0);
    check_eq("t1_full_busy", busy, 4'hF);
    tick();
    check_eq("t1_full_hold", ctrl.valid, 0);
    // Done arrives: accept in the same cycle, grant wraps to 0
    flags.done = 1'b1;
    settle();
    check_eq("t1_full_done_valid", ctrl.valid, 1);
    check_eq("t1_grant_wrap", req_ready, 4'b0001);
    exp_q.push_back(4'b0001);
    tick();
    req_valid = '0;
    check_eq("t1_done", done, exp_q.pop_front());
    check_eq("t1_head", active_id, 1);
    check_eq("t1_busy_pushpop", busy, 4'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t1_drain_done", done, exp_q.pop_front());
    end
    flags.done = 1'b0;
    check_eq("t1_drain_busy", busy, 0);
    check_eq("t1_drain_active", active_valid, 0);
    tick();
    check_eq("t1_done_clear", done, 0);
    check_eq("t1_no_error", error, 0);

    // Completion order: requester 2 then 1
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    req_valid = 4'b0100;
    settle();
    check_eq("t2_grant2", req_ready, 4'b0100);
    exp_q.push_back(4'b0100);
    tick();
    req_valid = 4'b0010;
    settle();
    check_eq("t2_grant1", req_ready, 4'b0010);
    exp_q.push_back(4'b0010);
    tick();
    req_valid = '0;
    check_eq("t2_busy", busy, 4'b0110);
    check_eq("t2_head", active_id, 2);
    flags.done = 1'b1;
    tick();
    check_eq("t2_done_a", done, exp_q.pop_front());
    check_eq("t2_busy_a", busy, 4'b0010);
    check_eq("t2_head_a", active_id, 1);
    tick();
    flags.done = 1'b0;
    check_eq("t2_done_b", done, exp_q.pop_front());
    check_eq("t2_busy_b", busy, 0);
    check_eq("t2_idle", active_valid, 0);
    tick();
    check_eq("t2_done_clear", done, 0);

    // Back-pressure: rr_ptr is 2, requesters 3 and 1 valid, sink not ready
    req_valid   = 4'b1010;
    flags.ready = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      check_eq("t3_stall_valid", ctrl.valid, 1);
      check_eq("t3_stall_base", ctrl.addressgen_ctrl.base_addr, 32'h4000);
      check_eq("t3_stall_ready", req_ready, 0);
      tick();
    end
    flags.ready = 1'b1;
    settle();
    check_eq("t3_accept", req_ready, 4'b1000);
    tick();
    check_eq("t3_next_grant", req_ready, 4'b0010);
    req_valid = '0;
    check_eq("t3_head", active_id, 3);
    flags.done = 1'b1;
    tick();
    flags.done = 1'b0;
    check_eq("t3_done", done, 4'b1000);
    tick();

    // Spurious done, then clear
    flags.done = 1'b1;
    tick();
    flags.done = 1'b0;
    check_eq("t4_error", error, 1);
    check_eq("t4_no_done", done, 0);
    tick();
    check_eq("t4_error_sticky", error, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t4_error_cleared", error, 0);

    // Clear with two jobs outstanding
    req_valid = 4'hF;
    settle();
    check_eq("t5_grant0", req_ready, 4'b0001);
    tick();
    check_eq("t5_grant1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    check_eq("t5_busy", busy, 4'b0011);
    check_eq("t5_active", active_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t5_clr_busy", busy, 0);
    check_eq("t5_clr_active", active_valid, 0);
    check_eq("t5_clr_state", state, IDLE);
    req_valid = 4'hF;
    settle();
    check_eq("t5_restart_grant", req_ready, 4'b0001);

    // Enable low: no request to the sink, no acceptance
    enable = 1'b0;
    settle();
    check_eq("t6_en_valid", ctrl.valid, 0);
    check_eq("t6_en_ready", req_ready, 0);
    tick();
    check_eq("t6_en_busy", busy, 0);
    enable    = 1'b1;
    req_valid = '0;

    // Asynchronous reset with a job outstanding
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check_eq("t7_busy", busy, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_busy", busy, 0);
    check_eq("t7_rst_active", active_valid, 0);
    check_eq("t7_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
